// File: rtl/wb_bus_arbiter_if.sv
// Wishbone arbiter bus bundle: the per-master request buses plus the shared slave port.
// Latency: none. It only carries the signals.
// Backpressure: none of its own. Flow control is the Wishbone ACK/ERR handshake carried inside.
//
// Ports are grouped by role:
//   master modport : environment side. It drives master requests and the slave's
//                    read data/ACK, and sees grants, ACK/ERR and the routed slave request.
//   slave  modport : arbiter side. It receives master requests and serves them onto
//                    the single shared slave.
// Master buses are flattened: master i occupies slice [i*W +: W].
interface wb_bus_arbiter_if #(
   parameter int NUM_MASTERS = 2,
   parameter int DATA_WIDTH  = 32,
   parameter int ADR_WIDTH   = 8,
   parameter int SEL_WIDTH   = 3
);
   logic [NUM_MASTERS-1:0]            M_CYC_I;
   logic [NUM_MASTERS-1:0]            M_STB_I;
   logic [NUM_MASTERS-1:0]            M_WE_I;
   logic [NUM_MASTERS*ADR_WIDTH-1:0]  M_ADR_I;
   logic [NUM_MASTERS*SEL_WIDTH-1:0]  M_SEL_I;
   logic [NUM_MASTERS*DATA_WIDTH-1:0] M_DATA_I;
   logic [DATA_WIDTH-1:0]             M_DATA_O;
   logic [NUM_MASTERS-1:0]            M_ACK_O;
   logic [NUM_MASTERS-1:0]            M_ERR_O;
   logic [NUM_MASTERS-1:0]            M_GNT_O;
   logic                              S_CYC_O;
   logic                              S_STB_O;
   logic                              S_WE_O;
   logic [ADR_WIDTH-1:0]              S_ADR_O;
   logic [SEL_WIDTH-1:0]              S_SEL_O;
   logic [DATA_WIDTH-1:0]             S_DATA_O;
   logic [DATA_WIDTH-1:0]             S_DATA_I;
   logic                              S_ACK_I;

   modport master (
      output M_CYC_I, M_STB_I, M_WE_I, M_ADR_I, M_SEL_I, M_DATA_I, S_DATA_I, S_ACK_I,
      input  M_DATA_O, M_ACK_O, M_ERR_O, M_GNT_O,
      input  S_CYC_O, S_STB_O, S_WE_O, S_ADR_O, S_SEL_O, S_DATA_O
   );

   modport slave (
      input  M_CYC_I, M_STB_I, M_WE_I, M_ADR_I, M_SEL_I, M_DATA_I, S_DATA_I, S_ACK_I,
      output M_DATA_O, M_ACK_O, M_ERR_O, M_GNT_O,
      output S_CYC_O, S_STB_O, S_WE_O, S_ADR_O, S_SEL_O, S_DATA_O
   );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NUM_MASTERS masters. Each CYC tenure is granted as a whole.
// Latency: grant is 1 cycle after the request. Request, ACK and read data pass through combinationally.
// Backpressure: the owner waits on the slave's ACK. A watchdog ends a stall with ERR after TIMEOUT cycles.
//
// Ports:
//   CLK_I : clock. All state changes on the rising edge.
//   RST_I : asynchronous active-high reset.
//   bus   : wb_bus_arbiter_if.slave, which carries
//             M_CYC/STB/WE/ADR/SEL/DATA_I : flattened master requests
//             M_DATA_O                    : slave read data, broadcast to every master
//             M_ACK_O, M_ERR_O            : owner bit only
//             M_GNT_O                     : registered one-hot grant
//             S_*                         : the shared slave port
module wb_bus_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int DATA_WIDTH  = 32,
   parameter int ADR_WIDTH   = 8,
   parameter int SEL_WIDTH   = 3,
   parameter int TIMEOUT     = 16
) (
   input  logic             CLK_I,
   input  logic             RST_I,
   wb_bus_arbiter_if.slave  bus
);

   localparam int IDX_W = (NUM_MASTERS > 2) ? 2 : 1;
   localparam logic [NUM_MASTERS-1:0] ONE       = NUM_MASTERS'(1);
   localparam logic [NUM_MASTERS-1:0] LAST_INIT = ONE << (NUM_MASTERS - 1);
   localparam logic [7:0]             WD_LAST   = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, OWNED, ABORT} state_t;

   state_t                 state;
   logic [NUM_MASTERS-1:0] gnt;        // current owner, one-hot, zero when idle
   logic [NUM_MASTERS-1:0] last_gnt;   // most recent owner, one-hot
   logic [IDX_W-1:0]       owner_idx;  // binary form of gnt, used to steer the wide buses
   logic                   err_q;
   logic [7:0]             wd_cnt;

   logic [NUM_MASTERS-1:0] req_hi;
   logic [NUM_MASTERS-1:0] pick_src;
   logic [NUM_MASTERS-1:0] pick_gnt;
   logic [IDX_W-1:0]       pick_idx;
   logic                   own_cyc;
   logic                   own_stb;
   logic                   own_we;
   logic                   granted;
   logic                   owned;

   // Round-robin pick. Requests strictly above the last owner take priority.
   // If there are none, wrap around to the lowest requester.
   // With last_gnt one-hot, (last_gnt | (last_gnt - 1)) covers the last owner and all bits below it.
   always_comb begin
      req_hi   = bus.M_CYC_I & ~(last_gnt | (last_gnt - ONE));
      pick_src = (|req_hi) ? req_hi : bus.M_CYC_I;
      pick_gnt = pick_src & (~pick_src + ONE);   // isolate the lowest set bit
      pick_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (pick_gnt == (ONE << i)) begin
            pick_idx = IDX_W'(i);
         end
      end
   end

   assign own_cyc = |(bus.M_CYC_I & gnt);
   assign own_stb = |(bus.M_STB_I & gnt);
   assign own_we  = |(bus.M_WE_I  & gnt);
   assign granted = (state != IDLE);
   assign owned   = (state == OWNED);

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state     <= IDLE;
         gnt       <= '0;
         last_gnt  <= LAST_INIT;
         owner_idx <= '0;
         err_q     <= 1'b0;
         wd_cnt    <= '0;
      end else begin
         err_q <= 1'b0;
         case (state)
            IDLE: begin
               wd_cnt <= '0;
               if (|bus.M_CYC_I) begin
                  gnt       <= pick_gnt;
                  last_gnt  <= pick_gnt;
                  owner_idx <= pick_idx;
                  state     <= OWNED;
               end
            end
            OWNED: begin
               // Release beats the timeout, and ACK beats the timeout.
               if (!own_cyc) begin
                  gnt    <= '0;
                  wd_cnt <= '0;
                  state  <= IDLE;
               end else if (bus.S_ACK_I || !own_stb) begin
                  wd_cnt <= '0;
               end else if (wd_cnt == WD_LAST) begin
                  err_q  <= 1'b1;
                  wd_cnt <= '0;
                  state  <= ABORT;
               end else begin
                  wd_cnt <= wd_cnt + 8'd1;
               end
            end
            ABORT: begin
               // Grant is held so no other master sees the slave mid-cycle.
               // It is released only when the owner drops CYC.
               if (!own_cyc) begin
                  gnt   <= '0;
                  state <= IDLE;
               end
            end
            default: begin
               gnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.M_DATA_O = bus.S_DATA_I;
   assign bus.M_GNT_O  = gnt;
   assign bus.M_ACK_O  = owned ? (gnt & {NUM_MASTERS{bus.S_ACK_I}}) : '0;
   assign bus.M_ERR_O  = err_q ? gnt : '0;

   assign bus.S_CYC_O  = owned & own_cyc;
   assign bus.S_STB_O  = owned & own_stb;
   assign bus.S_WE_O   = granted & own_we;
   assign bus.S_ADR_O  = granted ? ADR_WIDTH'(bus.M_ADR_I >> (int'(owner_idx) * ADR_WIDTH)) : '0;
   assign bus.S_SEL_O  = granted ? SEL_WIDTH'(bus.M_SEL_I >> (int'(owner_idx) * SEL_WIDTH)) : '0;
   assign bus.S_DATA_O = granted ? DATA_WIDTH'(bus.M_DATA_I >> (int'(owner_idx) * DATA_WIDTH)) : '0;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter with two masters and TIMEOUT=16.
// Latency: inputs are driven 1 time unit after each rising edge, and outputs are checked before the next edge.
// Backpressure: the slave ACK is driven by hand to create stalls and timeouts.
module tb_wb_bus_arbiter;
   localparam int NM = 2;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int SW = 3;
   localparam int TO = 16;

   logic CLK_I = 1'b0;
   logic RST_I;
   int   checks   = 0;
   int   failures = 0;
   logic [1:0] exp_gnt;

   wb_bus_arbiter_if #(.NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADR_WIDTH(AW), .SEL_WIDTH(SW)) bus ();

   wb_bus_arbiter #(
      .NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADR_WIDTH(AW), .SEL_WIDTH(SW), .TIMEOUT(TO)
   ) dut (
      .CLK_I(CLK_I),
      .RST_I(RST_I),
      .bus  (bus)
   );

   always #5 CLK_I = ~CLK_I;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK_I);
      #1;
   endtask

   initial begin
      RST_I        = 1'b1;
      bus.M_CYC_I  = '0;
      bus.M_STB_I  = '0;
      bus.M_WE_I   = '0;
      bus.M_ADR_I  = '0;
      bus.M_SEL_I  = '0;
      bus.M_DATA_I = '0;
      bus.S_DATA_I = '0;
      bus.S_ACK_I  = 1'b0;
      #2;
      chk("rst_gnt",  bus.M_GNT_O, 2'b00);
      chk("rst_scyc", bus.S_CYC_O, 1'b0);
      chk("rst_err",  bus.M_ERR_O, 2'b00);
      chk("rst_ack",  bus.M_ACK_O, 2'b00);
      tick();
      RST_I = 1'b0;

      // Tenure 1: both masters request, and master 0 wins the first tie. Master 0 writes.
      bus.M_CYC_I  = 2'b11;
      bus.M_STB_I  = 2'b01;
      bus.M_WE_I   = 2'b01;
      bus.M_ADR_I  = {8'h20, 8'h10};
      bus.M_SEL_I  = {3'b001, 3'b111};
      bus.M_DATA_I = {32'h1234_5678, 32'hA5A5_A5A5};
      #1;
      chk("pre_gnt",  bus.M_GNT_O, 2'b00);
      chk("pre_scyc", bus.S_CYC_O, 1'b0);
      tick();
      chk("gnt_m0",   bus.M_GNT_O,  2'b01);
      chk("w_scyc",   bus.S_CYC_O,  1'b1);
      chk("w_sstb",   bus.S_STB_O,  1'b1);
      chk("w_swe",    bus.S_WE_O,   1'b1);
      chk("w_sadr",   bus.S_ADR_O,  8'h10);
      chk("w_ssel",   bus.S_SEL_O,  3'b111);
      chk("w_sdata",  bus.S_DATA_O, 32'hA5A5_A5A5);
      bus.S_DATA_I = 32'hDEAD_BEEF;
      bus.S_ACK_I  = 1'b1;
      #1;
      chk("w_ack",    bus.M_ACK_O,  2'b01);
      chk("w_mdata",  bus.M_DATA_O, 32'hDEAD_BEEF);
      tick();
      bus.S_ACK_I = 1'b0;
      bus.M_STB_I = 2'b00;
      bus.M_CYC_I = 2'b10;
      #1;
      chk("drop_scyc", bus.S_CYC_O, 1'b0);
      tick();
      chk("idle1_gnt",  bus.M_GNT_O, 2'b00);
      chk("idle1_scyc", bus.S_CYC_O, 1'b0);
      bus.M_CYC_I = 2'b11;
      tick();
      chk("gnt_m1", bus.M_GNT_O, 2'b10);

      // Tenure 2: master 1 reads address 0x10, and the slave returns the written word.
      bus.M_STB_I  = 2'b10;
      bus.M_WE_I   = 2'b00;
      bus.M_ADR_I  = {8'h10, 8'h33};
      bus.S_DATA_I = 32'hA5A5_A5A5;
      bus.S_ACK_I  = 1'b1;
      #1;
      chk("r_sadr",  bus.S_ADR_O,  8'h10);
      chk("r_swe",   bus.S_WE_O,   1'b0);
      chk("r_ssel",  bus.S_SEL_O,  3'b001);
      chk("r_sdata", bus.S_DATA_O, 32'h1234_5678);
      chk("r_mdata", bus.M_DATA_O, 32'hA5A5_A5A5);
      chk("r_ack",   bus.M_ACK_O,  2'b10);
      tick();
      bus.S_ACK_I = 1'b0;
      bus.M_STB_I = 2'b00;
      bus.M_CYC_I = 2'b01;
      tick();
      chk("idle2_gnt", bus.M_GNT_O, 2'b00);
      bus.M_CYC_I = 2'b11;
      tick();
      exp_gnt = 2'b01;
      chk("alt_gnt3", bus.M_GNT_O, exp_gnt);

      // Tenures 4 to 6: the grant alternates with one idle cycle between tenures.
      for (int t = 4; t <= 6; t++) begin
         bus.M_CYC_I = ~exp_gnt;
         tick();
         chk("rel_idle", bus.M_GNT_O, 2'b00);
         bus.M_CYC_I = 2'b11;
         tick();
         exp_gnt = ~exp_gnt;
         chk("alt_gnt", bus.M_GNT_O, exp_gnt);
      end

      // Watchdog: master 1 stalls, and master 0 keeps requesting without effect.
      bus.M_STB_I = 2'b10;
      bus.S_ACK_I = 1'b0;
      for (int i = 1; i <= TO - 1; i++) begin
         tick();
         chk("wd_noerr", bus.M_ERR_O, 2'b00);
         chk("wd_scyc",  bus.S_CYC_O, 1'b1);
      end
      tick();
      chk("wd_err",     bus.M_ERR_O, 2'b10);
      chk("abort_scyc", bus.S_CYC_O, 1'b0);
      chk("abort_sstb", bus.S_STB_O, 1'b0);
      chk("abort_gnt",  bus.M_GNT_O, 2'b10);
      tick();
      chk("err_pulse",  bus.M_ERR_O, 2'b00);
      chk("abort_hold", bus.M_GNT_O, 2'b10);
      bus.M_CYC_I = 2'b01;
      bus.M_STB_I = 2'b00;
      tick();
      chk("abort_rel", bus.M_GNT_O, 2'b00);
      tick();
      chk("gnt_after_abort", bus.M_GNT_O, 2'b01);

      // ACK on the 16th stalled cycle beats the timeout and restarts the count.
      bus.M_STB_I = 2'b01;
      for (int i = 1; i <= TO - 2; i++) begin
         tick();
         chk("st_noerr", bus.M_ERR_O, 2'b00);
      end
      tick();
      bus.S_ACK_I = 1'b1;
      #1;
      chk("ack16", bus.M_ACK_O, 2'b01);
      tick();
      bus.S_ACK_I = 1'b0;
      chk("ack16_noerr", bus.M_ERR_O, 2'b00);
      chk("ack16_scyc",  bus.S_CYC_O, 1'b1);
      for (int i = 1; i <= TO - 1; i++) begin
         tick();
         chk("st2_noerr", bus.M_ERR_O, 2'b00);
      end
      tick();
      chk("st2_err", bus.M_ERR_O, 2'b01);
      bus.M_CYC_I = 2'b00;
      bus.M_STB_I = 2'b00;
      tick();
      chk("st2_rel", bus.M_GNT_O, 2'b00);
      bus.M_CYC_I = 2'b01;
      tick();
      chk("pre_rst_gnt", bus.M_GNT_O, 2'b01);

      // Reset asserted between edges while master 0 owns the bus.
      #2;
      RST_I = 1'b1;
      #1;
      chk("rst_mid_gnt",  bus.M_GNT_O, 2'b00);
      chk("rst_mid_scyc", bus.S_CYC_O, 1'b0);
      bus.M_CYC_I = 2'b11;
      tick();
      RST_I = 1'b0;
      tick();
      chk("post_rst_gnt", bus.M_GNT_O, 2'b01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
